bank_timing_array: RTL and testbench

- Parametrised per-bank DDR timing tracker for the DRAM emulation path.
- Decodes each command by {bg,ba} and runs one timing FSM per bank; PRA/REF are broadcast to all banks.
- Enforces tRCD/tRP/tRAS/tRFC/tCCD, handles auto-precharge, flags illegal commands and generates the read-data-valid window.
- Sits between the command decoder and the data-path/bank storage.

---
 rtl/bank_timing_array.sv | 228 ++++++++++++++++++++++
 tb/tb_bank_timing_array.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bank_timing_array.sv
// Per-bank DDR timing tracker: one timing FSM per bank, a shared tCCD counter,
// and shift-register generated read/write data windows.
module bank_timing_array #(
  parameter int  BGWIDTH = 2,
  parameter int  BAWIDTH = 2,
  parameter int  TRCD    = 14,
  parameter int  TRP     = 14,
  parameter int  TRAS    = 32,
  parameter int  TRFC    = 260,
  parameter int  TCL     = 14,
  parameter int  TBL     = 4,
  parameter int  CNTW    = 9,
  localparam int BGW     = (BGWIDTH > 0) ? BGWIDTH : 1,
  localparam int AW      = BGWIDTH + BAWIDTH,
  localparam int NB      = 1 << AW
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [BGW-1:0]     bg,
  input  logic [BAWIDTH-1:0] ba,
  input  logic               ACT,
  input  logic               PR,
  input  logic               PRA,
  input  logic               RD,
  input  logic               RDA,
  input  logic               WR,
  input  logic               WRA,
  input  logic               REF,
  output logic [NB-1:0]      bank_open,
  output logic [NB-1:0]      bank_busy,
  output logic               cmd_legal,
  output logic               cmd_err,
  output logic [AW-1:0]      err_bank,
  output logic               rd_valid,
  output logic               wr_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVATING,
    S_ACTIVE,
    S_PRECHARGING,
    S_REFRESHING
  } bank_state_e;

  // Read window bits TCL-1 .. TCL+TBL-2 of the shift register map to the
  // cycles t+TCL .. t+TCL+TBL-1 after the read edge t.
  localparam int RDW = TCL + TBL - 1;

  bank_state_e     state_q   [NB];
  bank_state_e     state_d   [NB];
  bank_state_e     eff_state [NB];
  logic [CNTW-1:0] cnt_q     [NB];
  logic [CNTW-1:0] cnt_d     [NB];
  logic [CNTW-1:0] ras_q     [NB];
  logic [CNTW-1:0] ras_d     [NB];
  logic [NB-1:0]   pend_q, pend_d;
  logic [CNTW-1:0] tccd_q, tccd_d;
  logic [RDW-1:0]  rd_sr_q, rd_sr_d;
  logic [TBL-1:0]  wr_sr_q, wr_sr_d;
  logic [NB-1:0]   open_q, open_d;
  logic [NB-1:0]   busy_q, busy_d;
  logic            cmd_legal_q;
  logic            cmd_err_q, cmd_err_d;
  logic [AW-1:0]   err_bank_q, err_bank_d;

  logic [AW-1:0]   sel;
  logic [7:0]      cmd_vec;
  logic            cmd_any, cmd_multi;
  logic            all_idle, pra_ok, rw_ok;
  logic            legal, illegal, rd_fire, wr_fire;
  bank_state_e     tgt_state;
  logic [CNTW-1:0] tgt_ras;
  logic            tgt_pend;

  if (BGWIDTH > 0) begin : g_bg
    assign sel = {bg, ba};
  end else begin : g_nobg
    assign sel = ba;
  end

  // Command decode and legality. A bank whose counter has reached zero is
  // treated as already in its follow-on state, so a command landing exactly
  // on the timing boundary is accepted.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update so
    // no path leaves it unassigned and no latch is inferred.
    cmd_vec   = {ACT, PR, PRA, RD, RDA, WR, WRA, REF};
    cmd_any   = |cmd_vec;
    cmd_multi = |(cmd_vec & (cmd_vec - 8'd1));
    all_idle  = 1'b1;
    pra_ok    = 1'b1;
    for (int i = 0; i < NB; i++) begin
      eff_state[i] = state_q[i];
      if (cnt_q[i] == '0) begin
        if (state_q[i] == S_ACTIVATING) begin
          eff_state[i] = S_ACTIVE;
        end else if (state_q[i] == S_PRECHARGING || state_q[i] == S_REFRESHING) begin
          eff_state[i] = S_IDLE;
        end
      end
      if (eff_state[i] != S_IDLE) all_idle = 1'b0;
      if (!(eff_state[i] == S_IDLE || (eff_state[i] == S_ACTIVE && ras_q[i] == '0))) begin
        pra_ok = 1'b0;
      end
    end

    tgt_state = eff_state[sel];
    tgt_ras   = ras_q[sel];
    tgt_pend  = pend_q[sel];
    rw_ok     = (tgt_state == S_ACTIVE) && !tgt_pend && (tccd_q == '0);

    legal = 1'b0;
    if (cmd_any && !cmd_multi) begin
      if (ACT)      legal = (tgt_state == S_IDLE);
      else if (PR)  legal = (tgt_state == S_IDLE) || (tgt_state == S_ACTIVE && tgt_ras == '0);
      else if (PRA) legal = pra_ok;
      else if (REF) legal = all_idle;
      else          legal = rw_ok;
    end
    illegal = cmd_any && !legal;
    rd_fire = legal && (RD || RDA);
    wr_fire = legal && (WR || WRA);
  end

  // Per-bank next state, shared tCCD counter and data windows.
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      state_d[i] = eff_state[i];
      cnt_d[i]   = (cnt_q[i] != '0) ? cnt_q[i] - CNTW'(1) : '0;
      ras_d[i]   = (ras_q[i] != '0) ? ras_q[i] - CNTW'(1) : '0;
      pend_d[i]  = pend_q[i];

      // The internal auto-precharge issues one cycle after its conditions are
      // observed, hence the full TRP load rather than TRP-1.
      if (eff_state[i] == S_ACTIVE && pend_q[i] && ras_q[i] == '0 && tccd_q == '0) begin
        state_d[i] = S_PRECHARGING;
        cnt_d[i]   = CNTW'(TRP);
        pend_d[i]  = 1'b0;
      end

      if (legal) begin
        if (sel == AW'(i)) begin
          if (ACT) begin
            state_d[i] = S_ACTIVATING;
            cnt_d[i]   = CNTW'(TRCD - 1);
            ras_d[i]   = CNTW'(TRAS - 1);
          end
          if (RDA || WRA) pend_d[i] = 1'b1;
          if (PR && eff_state[i] == S_ACTIVE) begin
            state_d[i] = S_PRECHARGING;
            cnt_d[i]   = CNTW'(TRP - 1);
            pend_d[i]  = 1'b0;
          end
        end
        if (PRA && eff_state[i] == S_ACTIVE) begin
          state_d[i] = S_PRECHARGING;
          cnt_d[i]   = CNTW'(TRP - 1);
          pend_d[i]  = 1'b0;
        end
        if (REF) begin
          state_d[i] = S_REFRESHING;
          cnt_d[i]   = CNTW'(TRFC - 1);
        end
      end

      open_d[i] = (state_d[i] == S_ACTIVE);
      busy_d[i] = (state_d[i] == S_ACTIVATING) || (state_d[i] == S_PRECHARGING) ||
                  (state_d[i] == S_REFRESHING);
    end

    if (rd_fire || wr_fire) tccd_d = CNTW'(TBL - 1);
    else                    tccd_d = (tccd_q != '0) ? tccd_q - CNTW'(1) : '0;

    rd_sr_d = (rd_sr_q << 1) | RDW'(rd_fire);
    wr_sr_d = (wr_sr_q << 1) | TBL'(wr_fire);

    cmd_err_d  = cmd_err_q | illegal;
    err_bank_d = (illegal && !cmd_err_q) ? sel : err_bank_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the per-bank counter arrays are reset along with the state
      // because the timing checks read them from the very first command.
      for (int i = 0; i < NB; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
        ras_q[i]   <= '0;
      end
      pend_q      <= '0;
      tccd_q      <= '0;
      rd_sr_q     <= '0;
      wr_sr_q     <= '0;
      open_q      <= '0;
      busy_q      <= '0;
      cmd_legal_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      err_bank_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      for (int i = 0; i < NB; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        ras_q[i]   <= ras_d[i];
      end
      pend_q      <= pend_d;
      tccd_q      <= tccd_d;
      rd_sr_q     <= rd_sr_d;
      wr_sr_q     <= wr_sr_d;
      open_q      <= open_d;
      busy_q      <= busy_d;
      cmd_legal_q <= legal;
      cmd_err_q   <= cmd_err_d;
      err_bank_q  <= err_bank_d;
    end
  end

  assign bank_open = open_q;
  assign bank_busy = busy_q;
  assign cmd_legal = cmd_legal_q;
  assign cmd_err   = cmd_err_q;
  assign err_bank  = err_bank_q;
  assign rd_valid  = |rd_sr_q[RDW-1:TCL-1];
  assign wr_valid  = |wr_sr_q;

endmodule

// File: tb/tb_bank_timing_array.sv
// Directed bench for bank_timing_array: a command/expectation table plus
// hand-written sequences for data windows, refresh and mid-burst reset.
module tb_bank_timing_array;

  localparam int NB = 16;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [1:0]      bg, ba;
  logic            ACT, PR, PRA, RD, RDA, WR, WRA, REF;
  logic [NB-1:0]   bank_open, bank_busy;
  logic            cmd_legal, cmd_err;
  logic [3:0]      err_bank;
  logic            rd_valid, wr_valid;

  int total = 0;
  int bad   = 0;
  int nxt   = 0;   // index of the next rising edge since reset release

  bank_timing_array dut (
    .clk(clk), .reset_n(reset_n), .bg(bg), .ba(ba),
    .ACT(ACT), .PR(PR), .PRA(PRA), .RD(RD), .RDA(RDA), .WR(WR), .WRA(WRA), .REF(REF),
    .bank_open(bank_open), .bank_busy(bank_busy), .cmd_legal(cmd_legal),
    .cmd_err(cmd_err), .err_bank(err_bank), .rd_valid(rd_valid), .wr_valid(wr_valid)
  );

  always #5 clk = ~clk;

  typedef enum {C_NOP, C_ACT, C_PR, C_PRA, C_RD, C_RDA, C_WR, C_WRA, C_REF, C_ACT_RD} cmd_e;

  typedef struct {
    bit         rst;
    int         at;
    cmd_e       cmd;
    logic [3:0] bank;
    logic       legal;
    logic       err;
    logic [3:0] eb;
    logic       open;
    logic       busy;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(bit rst, int at, cmd_e c, int b, bit lg, bit er, int eb,
                             bit op, bit bz);
    vec_t r;
    r.rst = rst; r.at = at; r.cmd = c; r.bank = 4'(b);
    r.legal = lg; r.err = er; r.eb = 4'(eb); r.open = op; r.busy = bz;
    return r;
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic drive(cmd_e c, logic [3:0] b);
    {bg, ba} = b;
    ACT = (c == C_ACT) || (c == C_ACT_RD);
    PR  = (c == C_PR);
    PRA = (c == C_PRA);
    RD  = (c == C_RD) || (c == C_ACT_RD);
    RDA = (c == C_RDA);
    WR  = (c == C_WR);
    WRA = (c == C_WRA);
    REF = (c == C_REF);
  endtask

  // Called at a falling edge; consumes one rising edge and returns at the
  // following falling edge, where outputs are sampled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    nxt++;
  endtask

  task automatic issue(cmd_e c, logic [3:0] b);
    drive(c, b);
    step();
    drive(C_NOP, b);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(C_NOP, 4'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    nxt = 0;
  endtask

  initial begin
    drive(C_NOP, 4'd0);
    @(negedge clk);
    check("reset bank_open", 64'(bank_open), 64'd0);
    check("reset bank_busy", 64'(bank_busy), 64'd0);
    check("reset cmd_legal", 64'(cmd_legal), 64'd0);
    check("reset cmd_err",   64'(cmd_err),   64'd0);
    check("reset err_bank",  64'(err_bank),  64'd0);
    check("reset rd_valid",  64'(rd_valid),  64'd0);
    check("reset wr_valid",  64'(wr_valid),  64'd0);

    //            rst at   cmd       bk lg er eb op bz
    // tRCD boundary
    vt.push_back(v(1,  0,  C_ACT,     5, 1, 0, 0, 0, 1));
    vt.push_back(v(0, 14,  C_RD,      5, 1, 0, 0, 1, 0));
    vt.push_back(v(1,  0,  C_ACT,     5, 1, 0, 0, 0, 1));
    vt.push_back(v(0, 13,  C_RD,      5, 0, 1, 5, 0, 1));
    vt.push_back(v(0, 14,  C_RD,      5, 1, 1, 5, 1, 0));
    // tRAS then tRP boundaries with explicit PR
    vt.push_back(v(1,  0,  C_ACT,     0, 1, 0, 0, 0, 1));
    vt.push_back(v(0, 31,  C_PR,      0, 0, 1, 0, 1, 0));
    vt.push_back(v(0, 32,  C_PR,      0, 1, 1, 0, 0, 1));
    vt.push_back(v(0, 45,  C_NOP,     0, 0, 1, 0, 0, 1));
    vt.push_back(v(0, 46,  C_ACT,     0, 1, 1, 0, 0, 1));
    // auto-precharge waits for tRAS
    vt.push_back(v(1,  0,  C_ACT,     3, 1, 0, 0, 0, 1));
    vt.push_back(v(0, 14,  C_RDA,     3, 1, 0, 0, 1, 0));
    vt.push_back(v(0, 31,  C_NOP,     3, 0, 0, 0, 1, 0));
    vt.push_back(v(0, 32,  C_NOP,     3, 0, 0, 0, 0, 1));
    vt.push_back(v(0, 46,  C_ACT,     3, 0, 1, 3, 0, 1));
    vt.push_back(v(0, 47,  C_ACT,     3, 1, 1, 3, 0, 1));
    // REF with an open bank, then tRFC boundary
    vt.push_back(v(1,  0,  C_ACT,     2, 1, 0, 0, 0, 1));
    vt.push_back(v(0, 20,  C_REF,     2, 0, 1, 2, 1, 0));
    vt.push_back(v(1,  0,  C_REF,     0, 1, 0, 0, 0, 1));
    vt.push_back(v(0, 259, C_ACT,     7, 0, 1, 7, 0, 1));
    vt.push_back(v(0, 260, C_ACT,     7, 1, 1, 7, 0, 1));
    vt.push_back(v(0, 261, C_NOP,     0, 0, 1, 7, 0, 0));
    // multi-strobe, first-error capture, tCCD spacing
    vt.push_back(v(1,  0,  C_ACT_RD,  1, 0, 1, 1, 0, 0));
    vt.push_back(v(0,  1,  C_ACT,     6, 1, 1, 1, 0, 1));
    vt.push_back(v(0, 20,  C_RD,      6, 1, 1, 1, 1, 0));
    vt.push_back(v(0, 22,  C_RD,      6, 0, 1, 1, 1, 0));
    vt.push_back(v(0, 24,  C_RD,      6, 1, 1, 1, 1, 0));
    vt.push_back(v(0, 28,  C_WR,      6, 1, 1, 1, 1, 0));
    vt.push_back(v(0, 30,  C_WR,      6, 0, 1, 1, 1, 0));
    // PRA gated by every bank's tRAS, PR to idle bank is a legal no-op
    vt.push_back(v(1,  0,  C_ACT,     0, 1, 0, 0, 0, 1));
    vt.push_back(v(0,  5,  C_ACT,     9, 1, 0, 0, 0, 1));
    vt.push_back(v(0, 20,  C_PRA,    12, 0, 1, 12, 0, 0));
    vt.push_back(v(0, 32,  C_PRA,     9, 0, 1, 12, 1, 0));
    vt.push_back(v(0, 37,  C_PRA,     9, 1, 1, 12, 0, 1));
    vt.push_back(v(0, 38,  C_PR,      4, 1, 1, 12, 0, 0));
    vt.push_back(v(0, 40,  C_NOP,     0, 0, 1, 12, 0, 1));

    foreach (vt[i]) begin
      if (vt[i].rst) do_reset();
      while (nxt < vt[i].at) step();
      issue(vt[i].cmd, vt[i].bank);
      check($sformatf("row%0d cmd_legal", i), 64'(cmd_legal), 64'(vt[i].legal));
      check($sformatf("row%0d cmd_err", i),   64'(cmd_err),   64'(vt[i].err));
      check($sformatf("row%0d err_bank", i),  64'(err_bank),  64'(vt[i].eb));
      check($sformatf("row%0d bank_open", i), 64'(bank_open[vt[i].bank]), 64'(vt[i].open));
      check($sformatf("row%0d bank_busy", i), 64'(bank_busy[vt[i].bank]), 64'(vt[i].busy));
    end

    // Read window 28..35 from reads at 14 and 18; write window 41..44 from WR at 40.
    do_reset();
    issue(C_ACT, 4'd5);
    for (int e = 1; e < 50; e++) begin
      cmd_e c;
      int   t;
      c = C_NOP;
      if (e == 14 || e == 18) c = C_RD;
      if (e == 40) c = C_WR;
      issue(c, 4'd5);
      t = e + 1;
      check($sformatf("rd_valid t=%0d", t), 64'(rd_valid), 64'(t >= 28 && t <= 35));
      check($sformatf("wr_valid t=%0d", t), 64'(wr_valid), 64'(t >= 41 && t <= 44));
    end

    // All banks busy for the whole refresh.
    do_reset();
    issue(C_REF, 4'd0);
    check("ref busy t=1", 64'(bank_busy), 64'hFFFF);
    for (int e = 1; e < 262; e++) begin
      int t;
      issue(C_NOP, 4'd0);
      t = e + 1;
      if (t == 130 || t >= 259)
        check($sformatf("ref busy t=%0d", t), 64'(bank_busy), (t <= 260) ? 64'hFFFF : 64'd0);
    end

    // Asynchronous reset in the middle of a read burst.
    do_reset();
    issue(C_ACT, 4'd5);
    while (nxt < 5) step();
    issue(C_WR, 4'd8);
    while (nxt < 14) step();
    issue(C_RD, 4'd5);
    while (nxt < 30) step();
    check("pre-reset rd_valid",  64'(rd_valid),     64'd1);
    check("pre-reset bank_open", 64'(bank_open[5]), 64'd1);
    check("pre-reset cmd_err",   64'(cmd_err),      64'd1);
    check("pre-reset err_bank",  64'(err_bank),     64'd8);
    #2 reset_n = 1'b0;
    #1;
    check("async rst rd_valid",  64'(rd_valid),  64'd0);
    check("async rst bank_open", 64'(bank_open), 64'd0);
    check("async rst cmd_err",   64'(cmd_err),   64'd0);
    check("async rst err_bank",  64'(err_bank),  64'd0);
    check("async rst bank_busy", 64'(bank_busy), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    nxt = 0;
    issue(C_ACT, 4'd5);
    check("post-reset ACT cmd_legal", 64'(cmd_legal),    64'd1);
    check("post-reset ACT cmd_err",   64'(cmd_err),      64'd0);
    check("post-reset ACT busy",      64'(bank_busy[5]), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
